// File: rtl/src_fetch_pkg.sv
// Shared types and constants for the source-operand fetch controller.
// Holds the FSM state encoding, default widths and their derived limits,
// and the increment applied to the source address when no stride is configured.
package src_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int N_DEF      = 10;
    localparam int LEN_W_DEF  = 6;
    localparam int DATA_W_DEF = 32;

    // Derived limits: address space wraps at ADDR_MAX, longest burst is CNT_MAX.
    localparam int ADDR_MAX = (1 << N_DEF) - 1;
    localparam int CNT_MAX  = (1 << LEN_W_DEF) - 1;

    localparam int DEFAULT_STRIDE = 1;

endpackage

// File: rtl/src_fetch_ctrl_if.sv
// Handshake/bus bundle between the PIM controller, the array read port and the
// downstream operand consumer. slave = fetch controller view, master = environment.
// Optional macro SRC_STRIDE_EN adds the stride input.
import src_fetch_pkg::*;

interface src_fetch_ctrl_if #(
    parameter int N      = N_DEF,
    parameter int LEN_W  = LEN_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              PIM_start;
    logic [N-1:0]      base_addr;
    logic [LEN_W-1:0]  len;
    logic              Mov_load;
    logic [N-1:0]      MOV_in;
    logic              rd_req;
    logic [N-1:0]      rd_addr;
    logic              rd_ack;
    logic [DATA_W-1:0] rd_data;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic              busy;
    logic              done;
`ifdef SRC_STRIDE_EN
    logic [N-1:0]      stride;
`endif

    modport slave (
        input  PIM_start, base_addr, len, Mov_load, MOV_in,
        input  rd_ack, rd_data, out_ready,
`ifdef SRC_STRIDE_EN
        input  stride,
`endif
        output rd_req, rd_addr, out_valid, out_data, busy, done
    );

    modport master (
        output PIM_start, base_addr, len, Mov_load, MOV_in,
        output rd_ack, rd_data, out_ready,
`ifdef SRC_STRIDE_EN
        output stride,
`endif
        input  rd_req, rd_addr, out_valid, out_data, busy, done
    );

endinterface

// File: rtl/src_addr_cnt.sv
// Source address register: start-load > mov-load > increment by i_step > hold.
// Ports: clk/rst_n (sync active-low), load strobes + values, i_inc/i_step, o_addr.
// Arithmetic is unsigned and wraps modulo 2^N.
module src_addr_cnt #(
    parameter int N = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load_start,
    input  logic [N-1:0] i_start_addr,
    input  logic         i_load_mov,
    input  logic [N-1:0] i_mov_addr,
    input  logic         i_inc,
    input  logic [N-1:0] i_step,
    output logic [N-1:0] o_addr
);
    logic [N-1:0] r_addr;

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_addr <= '0;
        else if (i_load_start)
            r_addr <= i_start_addr;
        else if (i_load_mov)
            r_addr <= i_mov_addr;
        else if (i_inc)
            r_addr <= r_addr + i_step;
    end

    assign o_addr = r_addr;

endmodule

// File: rtl/src_fetch_ctrl.sv
// Source-operand fetch controller: issues one array read per element (req/ack),
// then presents each word downstream (valid/ready); 1 cycle start->rd_req, 2 cycles/element.
// Ports: clk, rst_n (sync active-low), bus (src_fetch_ctrl_if.slave). Optional macro SRC_STRIDE_EN.
import src_fetch_pkg::*;

module src_fetch_ctrl #(
    parameter int N      = N_DEF,
    parameter int LEN_W  = LEN_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    src_fetch_ctrl_if.slave bus
);
    state_t            r_state;
    logic [LEN_W-1:0]  r_cnt;
    logic              r_rd_req;
    logic [N-1:0]      r_rd_addr;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic              r_busy;
    logic              r_done;

    logic              w_idle;
    logic              w_start_go;
    logic              w_mov_go;
    logic              w_ack_go;
    logic [N-1:0]      w_step;
    logic [N-1:0]      w_src_addr;

    assign w_idle     = (r_state == IDLE);
    // An empty burst never touches the address register; it only pulses done.
    assign w_start_go = w_idle && bus.PIM_start && (bus.len != '0);
    // Start has priority over a simultaneous MOV load.
    assign w_mov_go   = w_idle && bus.Mov_load && !bus.PIM_start;
    assign w_ack_go   = (r_state == REQ) && bus.rd_ack;

`ifdef SRC_STRIDE_EN
    logic [N-1:0] r_stride;

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_stride <= N'(DEFAULT_STRIDE);
        else if (w_start_go)
            r_stride <= bus.stride;
    end

    assign w_step = r_stride;
`else
    assign w_step = N'(DEFAULT_STRIDE);
`endif

    src_addr_cnt #(.N(N)) u_addr (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_load_start (w_start_go),
        .i_start_addr (bus.base_addr),
        .i_load_mov   (w_mov_go),
        .i_mov_addr   (bus.MOV_in),
        .i_inc        (w_ack_go),
        .i_step       (w_step),
        .o_addr       (w_src_addr)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_rd_req    <= 1'b0;
            r_rd_addr   <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.PIM_start) begin
                        if (bus.len != '0) begin
                            r_state   <= REQ;
                            r_cnt     <= bus.len;
                            r_rd_req  <= 1'b1;
                            r_rd_addr <= bus.base_addr;
                            r_busy    <= 1'b1;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (bus.rd_ack) begin
                        r_out_data  <= bus.rd_data;
                        r_out_valid <= 1'b1;
                        r_cnt       <= r_cnt - LEN_W'(1);
                        r_rd_req    <= 1'b0;
                        r_state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        if (r_cnt != '0) begin
                            // Address register already advanced on the ack.
                            r_state   <= REQ;
                            r_rd_req  <= 1'b1;
                            r_rd_addr <= w_src_addr;
                        end else begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.rd_req    = r_rd_req;
    assign bus.rd_addr   = r_rd_addr;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;

endmodule

// File: doc/src_fetch_ctrl.md
Name: src_fetch_ctrl

Overview:
- Read-side counterpart of the PIM destination register: sequences operand reads from the crossbar/memory array for a PIM operation.
- Holds a source address register loaded by a PIM start or a MOV. Issues one read request per element with a req/ack handshake, then forwards each returned word downstream with valid/ready.
- Sits between the PIM controller and the array read port, mirroring the destination address path on the write side.

Parameters:
- N, 10, source address width; wraps modulo 2^N.
- LEN_W, 6, width of the element-count field.
- DATA_W, 32, read data width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- PIM_start  in  1  start a fetch burst; accepted only in IDLE
- base_addr  in  N  start address captured on PIM_start
- len  in  LEN_W  element count captured on PIM_start; 0 is legal
- Mov_load  in  1  load source address from MOV_in; accepted only in IDLE
- MOV_in  in  N  address for Mov_load
- rd_req  out  1  read request to array
- rd_addr  out  N  read address; valid while rd_req=1
- rd_ack  in  1  array returns rd_data this cycle
- rd_data  in  DATA_W  read data, sampled when rd_ack=1
- out_valid  out  1  out_data valid
- out_data  out  DATA_W  fetched operand
- out_ready  in  1  downstream accepts out_data
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse when the burst completes
- stride  in  N  address increment (only with SRC_STRIDE_EN)

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE; src_addr=0; remaining count=0; rd_req=0; rd_addr=0; out_valid=0; out_data=0; busy=0; done=0. Reset mid-burst aborts immediately with no done pulse. A pending rd_ack after reset is ignored.
- States:
  - IDLE
    - PIM_start=1 and len≠0: capture src_addr=base_addr and cnt=len, go to REQ.
    - PIM_start=1 and len=0: pulse done next cycle and stay IDLE.
    - Mov_load=1 without PIM_start: src_addr<=MOV_in.
    - PIM_start and Mov_load together: PIM_start wins.
  - REQ: rd_req=1, rd_addr=src_addr (registered outputs). Stay in REQ until rd_ack.
    - On rd_ack: out_data<=rd_data, out_valid<=1, src_addr<=src_addr+1, cnt<=cnt-1, go to HOLD.
    - rd_ack in the same cycle rd_req first rises is legal (zero-wait array).
  - HOLD: rd_req=0. out_valid and out_data stay stable until out_ready=1.
    - On handshake with cnt≠0: go to REQ.
    - On handshake with cnt=0: go to DONE.
  - DONE: done=1 for exactly one cycle, out_valid=0, go to IDLE.
- Throughput: at most one element per 2 cycles with zero-wait ack and out_ready held high. Latency from PIM_start to first rd_req is 1 cycle.
- Address arithmetic: unsigned modulo 2^N, e.g. 2^N-1 +1 -> 0. cnt uses LEN_W bits; len=2^LEN_W-1 is the maximum burst.
- PIM_start and Mov_load are ignored while busy=1. rd_ack outside REQ is ignored.
- After a burst, src_addr holds last address+1, so a later Mov_load or PIM_start overwrites it.

Optional Feature:
- Macro SRC_STRIDE_EN.
- Defined: stride port exists, is captured on PIM_start into a stride register, and the address advances by the stride register (mod 2^N). stride=0 re-reads the same address len times.
- Undefined: no stride port; increment fixed at 1.

Decomposition:
- Shared package src_fetch_pkg holds:
  - typedef enum of states {IDLE, REQ, HOLD, DONE}
  - localparam widths derived from N/LEN_W
  - a default-stride constant of 1
- One natural sub-module, src_addr_cnt: an address register with priority start-load > mov-load > increment and hold otherwise, plus synchronous active-low reset. It is the read-side twin of the destination address register. The FSM stays in the top.

Test Plan:
- Reset then PIM_start, base_addr=0x010, len=3, ack after 1 cycle, out_ready=1 -> rd_addr sequence 0x010, 0x011, 0x012; three out_valid beats carrying the acked data; done pulses once; busy falls the cycle after done.
- Mov_load with MOV_in=0x155 in IDLE, then PIM_start together with Mov_load (MOV_in=0x0AA, base_addr=0x020, len=1) -> first rd_addr=0x020; Mov_load ignored.
- base_addr=0x3FE, len=4, N=10 -> rd_addr 0x3FE, 0x3FF, 0x000, 0x001.
- Backpressure: out_ready held low 5 cycles in HOLD -> out_valid and out_data stable, no new rd_req, cnt unchanged. Release -> next REQ.
- len=0 -> no rd_req; done pulses 1 cycle after PIM_start; busy stays 0.
- rst_n low during the 2nd REQ of a len=4 burst -> all outputs 0 next cycle, no done. A later PIM_start runs normally. With SRC_STRIDE_EN and stride=4, base=0x000, len=3 -> addresses 0x000, 0x004, 0x008.
